// File: rtl/rr_mux_sel_arbiter_pkg.sv
// rr_mux_sel_arbiter_pkg: shared sizes, state encodings and helpers for the round-robin mux-select arbiter
package rr_mux_sel_arbiter_pkg;
   localparam int N_REQ = 4;
   localparam int SEL_W = $clog2(N_REQ);
   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_GRANT = 1'b1;
   typedef logic [SEL_W-1:0] idx_t;
   typedef logic [N_REQ-1:0] vec_t;
   function automatic vec_t onehot(input idx_t i);
      return vec_t'(1) << i;
   endfunction
endpackage

// File: rtl/rr_mux_sel_arbiter_if.sv
// rr_mux_sel_arbiter_if: request/grant bundle between requesters (master) and the arbiter (slave)
interface rr_mux_sel_arbiter_if;
   import rr_mux_sel_arbiter_pkg::*;
   vec_t req;
   idx_t sel;
   vec_t gnt;
   logic gnt_valid;
   modport master(output req, input sel, gnt, gnt_valid);
   modport slave(input req, output sel, gnt, gnt_valid);
endinterface

// File: rtl/rr_mux_sel_arbiter_pick.sv
// rr_priority_pick: rotate-priority encoder, first set req bit searching cyclically from start_ptr
module rr_priority_pick
   import rr_mux_sel_arbiter_pkg::*;
(
   input  vec_t req,
   input  idx_t start_ptr,
   output idx_t idx,
   output logic found
);
   // scan highest offset first so the nearest set bit to start_ptr wins
   always_comb begin
      idx   = '0;
      found = 1'b0;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         if (req[start_ptr + idx_t'(k)]) begin
            idx   = start_ptr + idx_t'(k);
            found = 1'b1;
         end
      end
   end
endmodule

// File: rtl/rr_mux_sel_arbiter.sv
// rr_mux_sel_arbiter: round-robin arbiter with bounded bursts, driving a registered 4:1 mux select
module rr_mux_sel_arbiter
   import rr_mux_sel_arbiter_pkg::*;
#(
   parameter int MAX_HOLD = 4
) (
   input logic clk,
   input logic rst_n,
   rr_mux_sel_arbiter_if.slave arb
);
   localparam int HW = $clog2(MAX_HOLD + 1);
   localparam logic [HW-1:0] HMAX = HW'(MAX_HOLD);
   logic [0:0] st;
   idx_t sel_q, last_ptr, pick_idx;
   vec_t gnt_q, pick_req;
   logic valid_q, found, held, new_grant;
   logic [HW-1:0] hold_cnt;
   // owner still requesting: only the other sources compete for a rotation
   assign held      = (st == ST_GRANT) && arb.req[sel_q];
   assign pick_req  = held ? (arb.req & ~onehot(sel_q)) : arb.req;
   assign new_grant = found && (!held || (hold_cnt == HMAX));
   rr_priority_pick u_pick (
      .req      (pick_req),
      .start_ptr(last_ptr + idx_t'(1)),
      .idx      (pick_idx),
      .found    (found)
   );
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sel_q    <= '0;
         gnt_q    <= '0;
         valid_q  <= 1'b0;
         last_ptr <= idx_t'(N_REQ - 1);
         hold_cnt <= '0;
         st       <= ST_IDLE;
      end else if (new_grant) begin
         sel_q    <= pick_idx;
         gnt_q    <= onehot(pick_idx);
         valid_q  <= 1'b1;
         last_ptr <= pick_idx;
         hold_cnt <= HW'(1);
         st       <= ST_GRANT;
      end else if (held) begin
         if (hold_cnt != HMAX) hold_cnt <= hold_cnt + HW'(1);
      end else begin
         gnt_q   <= '0;
         valid_q <= 1'b0;
         st      <= ST_IDLE;
      end
   end
   assign arb.sel       = sel_q;
   assign arb.gnt       = gnt_q;
   assign arb.gnt_valid = valid_q;
endmodule

// File: tb/tb_rr_mux_sel_arbiter.sv
// tb_rr_mux_sel_arbiter: directed + random checks of the round-robin arbiter, MAX_HOLD=4 and MAX_HOLD=1
module tb_rr_mux_sel_arbiter;
   logic clk = 1'b0;
   logic rst_n = 1'b1;
   int tests = 0;
   int fails = 0;
   logic [3:0] din = 4'b1010;
   logic m0, m1, yb;
   rr_mux_sel_arbiter_if ia();
   rr_mux_sel_arbiter_if ib();
   rr_mux_sel_arbiter #(.MAX_HOLD(4)) dut_a (.clk(clk), .rst_n(rst_n), .arb(ia.slave));
   rr_mux_sel_arbiter #(.MAX_HOLD(1)) dut_b (.clk(clk), .rst_n(rst_n), .arb(ib.slave));
   always #5 clk = ~clk;
   // 4:1 mux from 2:1 muxes, steered by dut_b's select
   assign m0 = ib.sel[0] ? din[1] : din[0];
   assign m1 = ib.sel[0] ? din[3] : din[2];
   assign yb = ib.sel[1] ? m1 : m0;
   typedef struct {
      string      tag;
      logic [1:0] sel;
      logic [3:0] gnt;
      logic       y;
      bit         cy;
   } exp_t;
   exp_t q[$];
   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   task automatic step(input logic [3:0] r, input string tag, input logic [1:0] es,
                       input logic [3:0] eg, input logic ey, input bit cy);
      exp_t e;
      @(negedge clk);
      ia.req = r;
      e.tag = tag; e.sel = es; e.gnt = eg; e.y = ey; e.cy = cy;
      q.push_back(e);
      @(posedge clk);
      #1;
      e = q.pop_front();
      chk({e.tag, "_sel"}, 8'(ia.sel), 8'(e.sel));
      chk({e.tag, "_gnt"}, 8'(ia.gnt), 8'(e.gnt));
      chk({e.tag, "_valid"}, 8'(ia.gnt_valid), 8'(|e.gnt));
      if (e.cy) chk({e.tag, "_y"}, 8'(yb), 8'(e.y));
   endtask
   task automatic inv(input string tag, input logic [1:0] s, input logic [3:0] g, input logic v);
      chk({tag, "_onehot"}, 8'($onehot0(g)), 8'd1);
      chk({tag, "_valid"}, 8'(v), 8'(|g));
      chk({tag, "_selgnt"}, 8'(v ? g : 4'd0), 8'(v ? (4'd1 << s) : 4'd0));
   endtask
   initial begin
      int wa[4];
      int wb[4];
      ia.req = 4'b0000;
      ib.req = 4'b1111;
      #1 rst_n = 1'b0;
      #2;
      chk("reset_sel", 8'(ia.sel), 8'd0);
      chk("reset_gnt", 8'(ia.gnt), 8'd0);
      chk("reset_valid", 8'(ia.gnt_valid), 8'd0);
      @(posedge clk);
      #2 rst_n = 1'b1;
      for (int n = 0; n < 20; n++)
         step(4'b1111, "contend", 2'((n / 4) % 4), 4'd1 << ((n / 4) % 4), din[n % 4], 1'b1);
      step(4'b1010, "drop0", 2'd1, 4'b0010, 1'b0, 1'b0);
      step(4'b1000, "early_rel", 2'd3, 4'b1000, 1'b0, 1'b0);
      step(4'b0000, "idle0", 2'd3, 4'b0000, 1'b0, 1'b0);
      step(4'b0000, "idle1", 2'd3, 4'b0000, 1'b0, 1'b0);
      step(4'b1001, "wrap", 2'd0, 4'b0001, 1'b0, 1'b0);
      for (int n = 0; n < 10; n++)
         step(4'b0100, "single", 2'd2, 4'b0100, 1'b0, 1'b0);
      step(4'b0110, "rot_sat", 2'd1, 4'b0010, 1'b0, 1'b0);
      step(4'b0110, "burst", 2'd1, 4'b0010, 1'b0, 1'b0);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_sel", 8'(ia.sel), 8'd0);
      chk("midrst_gnt", 8'(ia.gnt), 8'd0);
      chk("midrst_valid", 8'(ia.gnt_valid), 8'd0);
      chk("midrst_gnt_b", 8'(ib.gnt), 8'd0);
      @(posedge clk);
      #2 rst_n = 1'b1;
      step(4'b0110, "post_rst", 2'd1, 4'b0010, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) begin
         wa[i] = 0;
         wb[i] = 0;
      end
      for (int c = 0; c < 1000; c++) begin
         @(negedge clk);
         inv("inv_a", ia.sel, ia.gnt, ia.gnt_valid);
         inv("inv_b", ib.sel, ib.gnt, ib.gnt_valid);
         for (int i = 0; i < 4; i++) begin
            wa[i] = (ia.req[i] && !ia.gnt[i]) ? wa[i] + 1 : 0;
            wb[i] = (ib.req[i] && !ib.gnt[i]) ? wb[i] + 1 : 0;
            chk("wait_a", 8'(wa[i] <= 13), 8'd1);
            chk("wait_b", 8'(wb[i] <= 4), 8'd1);
         end
         ia.req = 4'($urandom);
         ib.req = 4'($urandom);
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
